// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared access-size encodings and LSU state type
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_MERGE = 1'b1
    } lsu_state_e;

endpackage

// File: rtl/mem_lane_merge.sv
// rtl/mem_lane_merge.sv - byte-lane mask, store merge and load extract/extend
module mem_lane_merge
    import mem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  lane,
    input  logic        is_signed,
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    output logic [3:0]  byte_mask,
    output logic [31:0] merged,
    output logic [31:0] load_data
);

    logic [31:0] rep_data;
    logic [31:0] shifted;

    always_comb begin
        byte_mask = 4'b1111;
        rep_data  = wdata;
        if (size == SZ_BYTE) begin
            byte_mask = 4'b0001 << lane;
            rep_data  = {4{wdata[7:0]}};
        end else if (size == SZ_HALF) begin
            byte_mask = lane[1] ? 4'b1100 : 4'b0011;
            rep_data  = {2{wdata[15:0]}};
        end
    end

    // Replicated store data lines up with every lane, so the mask alone picks bytes.
    always_comb begin
        merged = old_word;
        for (int k = 0; k < 4; k++) begin
            if (byte_mask[k]) begin
                merged[8*k +: 8] = rep_data[8*k +: 8];
            end
        end
    end

    always_comb begin
        shifted = old_word >> {lane, 3'b000};
        if (size == SZ_BYTE) begin
            load_data = {{24{is_signed & shifted[7]}}, shifted[7:0]};
        end else if (size == SZ_HALF) begin
            load_data = {{16{is_signed & shifted[15]}}, shifted[15:0]};
        end else begin
            load_data = old_word;
        end
    end

endmodule

// File: rtl/mem_lsu.sv
// rtl/mem_lsu.sv - MEM-stage load/store unit with sub-word read-modify-write
module mem_lsu
    import mem_pkg::*;
#(
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MemReadM,
    input  logic              MemWriteM,
    input  logic [1:0]        MemSizeM,
    input  logic              MemSignedM,
    input  logic              FlushM,
    input  logic [31:0]       ALUOutM,
    input  logic [31:0]       WriteDataM,
    output logic [ADDR_W-1:0] DramA,
    output logic [31:0]       DramD,
    output logic              DramWe,
    input  logic [31:0]       DramSpo,
    output logic [31:0]       ReadDataM,
    output logic              StallM,
    output logic              MisalignM
);

    lsu_state_e        state_q, state_d;
    logic [31:0]       merged_q, merged_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    logic [3:0]  byte_mask;
    logic [31:0] merged_word;
    logic [31:0] load_data;
    logic        active;
    logic        fault;
    logic        access_ok;

    mem_lane_merge u_lane_merge (
        .size      (MemSizeM),
        .lane      (ALUOutM[1:0]),
        .is_signed (MemSignedM),
        .old_word  (DramSpo),
        .wdata     (WriteDataM),
        .byte_mask (byte_mask),
        .merged    (merged_word),
        .load_data (load_data)
    );

    assign active    = (MemReadM | MemWriteM) & ~FlushM;
    assign fault     = active & (((MemSizeM == SZ_HALF) & ALUOutM[0])
                               | ((&byte_mask) & (|ALUOutM[1:0]))
                               | (|ALUOutM[31:ADDR_W+2]));
    assign access_ok = active & ~fault;

    always_comb begin
        state_d   = state_q;
        merged_d  = merged_q;
        addr_d    = addr_q;
        DramA     = ALUOutM[ADDR_W+1:2];
        DramD     = WriteDataM;
        DramWe    = 1'b0;
        StallM    = 1'b0;
        MisalignM = 1'b0;
        ReadDataM = 32'h0;
        case (state_q)
            ST_IDLE: begin
                MisalignM = fault;
                if (access_ok && MemWriteM) begin
                    if (&byte_mask) begin
                        DramWe = 1'b1;
                    end else begin
                        StallM   = 1'b1;
                        merged_d = merged_word;
                        addr_d   = ALUOutM[ADDR_W+1:2];
                        state_d  = ST_MERGE;
                    end
                end else if (access_ok && MemReadM) begin
                    ReadDataM = load_data;
                end
            end
            ST_MERGE: begin
                // The stalled instruction is still presented here; it is deliberately ignored.
                DramA   = addr_q;
                DramD   = merged_q;
                DramWe  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (rst) begin
            DramWe    = 1'b0;
            StallM    = 1'b0;
            MisalignM = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            merged_q <= 32'h0;
            addr_q   <= '0;
        end else begin
            state_q  <= state_d;
            merged_q <= merged_d;
            addr_q   <= addr_d;
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
// tb/tb_mem_lsu.sv - directed scoreboard bench for mem_lsu
module tb_mem_lsu;

    localparam int ADDR_W = 7;
    localparam logic [1:0] SZB = 2'b00;
    localparam logic [1:0] SZH = 2'b01;
    localparam logic [1:0] SZW = 2'b10;

    logic              clk;
    logic              rst;
    logic              MemReadM;
    logic              MemWriteM;
    logic [1:0]        MemSizeM;
    logic              MemSignedM;
    logic              FlushM;
    logic [31:0]       ALUOutM;
    logic [31:0]       WriteDataM;
    logic [ADDR_W-1:0] DramA;
    logic [31:0]       DramD;
    logic              DramWe;
    logic [31:0]       DramSpo;
    logic [31:0]       ReadDataM;
    logic              StallM;
    logic              MisalignM;

    logic [31:0] mem [0:127];
    logic [31:0] sb [$];
    int tests;
    int fails;

    mem_lsu #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .MemReadM   (MemReadM),
        .MemWriteM  (MemWriteM),
        .MemSizeM   (MemSizeM),
        .MemSignedM (MemSignedM),
        .FlushM     (FlushM),
        .ALUOutM    (ALUOutM),
        .WriteDataM (WriteDataM),
        .DramA      (DramA),
        .DramD      (DramD),
        .DramWe     (DramWe),
        .DramSpo    (DramSpo),
        .ReadDataM  (ReadDataM),
        .StallM     (StallM),
        .MisalignM  (MisalignM)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign DramSpo = mem[DramA];
    always @(posedge clk) begin
        if (DramWe) mem[DramA] <= DramD;
    end

    task automatic chk(input string tag, input logic [31:0] obs);
        logic [31:0] expv;
        tests++;
        if (sb.size() == 0) begin
            fails++;
            $display("FAIL %s observed=%h expected=<scoreboard empty>", tag, obs);
        end else begin
            expv = sb.pop_front();
            assert (obs === expv) else begin
                fails++;
                $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
            end
        end
    endtask

    task automatic drv(input logic rd, input logic wr, input logic [1:0] sz,
                       input logic sgn, input logic fl,
                       input logic [31:0] addr, input logic [31:0] wd);
        MemReadM   = rd;
        MemWriteM  = wr;
        MemSizeM   = sz;
        MemSignedM = sgn;
        FlushM     = fl;
        ALUOutM    = addr;
        WriteDataM = wd;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        for (int i = 0; i < 128; i++) mem[i] = 32'h0;
        mem[4] = 32'h11223344;
        rst = 1'b1;
        drv(0, 1, SZW, 0, 0, 32'h10, 32'h0BADF00D);
        #2;
        sb.push_back(0); chk("reset_we", {31'b0, DramWe});
        sb.push_back(0); chk("reset_stall", {31'b0, StallM});
        sb.push_back(0); chk("reset_mis", {31'b0, MisalignM});
        drv(0, 0, SZW, 0, 0, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // sb 0xAB @ 0x11
        @(posedge clk); #1;
        drv(0, 1, SZB, 0, 0, 32'h11, 32'h000000AB);
        #1;
        sb.push_back(1); chk("sb_c1_stall", {31'b0, StallM});
        sb.push_back(0); chk("sb_c1_we", {31'b0, DramWe});
        sb.push_back(4); chk("sb_c1_addr", {25'b0, DramA});
        @(posedge clk); #2;
        sb.push_back(0); chk("sb_c2_stall", {31'b0, StallM});
        sb.push_back(1); chk("sb_c2_we", {31'b0, DramWe});
        sb.push_back(4); chk("sb_c2_addr", {25'b0, DramA});
        sb.push_back(32'h1122AB44); chk("sb_c2_data", DramD);
        @(posedge clk); #1;
        drv(0, 0, SZW, 0, 0, 32'h0, 32'h0);
        #1;
        sb.push_back(32'h1122AB44); chk("sb_mem4", mem[4]);

        // loads
        drv(1, 0, SZB, 1, 0, 32'h11, 32'h0); #1;
        sb.push_back(32'hFFFFFFAB); chk("lb_0x11", ReadDataM);
        drv(1, 0, SZB, 0, 0, 32'h11, 32'h0); #1;
        sb.push_back(32'h000000AB); chk("lbu_0x11", ReadDataM);
        drv(1, 0, SZH, 1, 0, 32'h12, 32'h0); #1;
        sb.push_back(32'h00001122); chk("lh_0x12", ReadDataM);
        drv(1, 0, SZW, 0, 0, 32'h10, 32'h0); #1;
        sb.push_back(32'h1122AB44); chk("lw_0x10", ReadDataM);

        // back-to-back sh 0xBEEF @0x12, sb 0x55 @0x10
        @(posedge clk); #1;
        drv(0, 1, SZH, 0, 0, 32'h12, 32'h0000BEEF);
        #1;
        sb.push_back(1); chk("b2b_c1_stall", {31'b0, StallM});
        @(posedge clk); #2;
        sb.push_back(0); chk("b2b_c2_stall", {31'b0, StallM});
        sb.push_back(32'hBEEFAB44); chk("b2b_c2_data", DramD);
        @(posedge clk); #1;
        drv(0, 1, SZB, 0, 0, 32'h10, 32'h00000055);
        #1;
        sb.push_back(1); chk("b2b_c3_stall", {31'b0, StallM});
        sb.push_back(32'hBEEFAB44); chk("b2b_c3_spo", DramSpo);
        @(posedge clk); #2;
        sb.push_back(1); chk("b2b_c4_we", {31'b0, DramWe});
        sb.push_back(32'hBEEFAB55); chk("b2b_c4_data", DramD);
        @(posedge clk); #1;
        drv(0, 0, SZW, 0, 0, 32'h0, 32'h0);
        #1;
        sb.push_back(32'hBEEFAB55); chk("b2b_mem4", mem[4]);

        // misaligned / out of range
        drv(0, 1, SZH, 0, 0, 32'h13, 32'h00001234); #1;
        sb.push_back(1); chk("sh13_mis", {31'b0, MisalignM});
        sb.push_back(0); chk("sh13_stall", {31'b0, StallM});
        sb.push_back(0); chk("sh13_we", {31'b0, DramWe});
        @(posedge clk); #1;
        drv(0, 1, SZW, 0, 0, 32'h200, 32'hDEADBEEF); #1;
        sb.push_back(32'hBEEFAB55); chk("sh13_mem4", mem[4]);
        sb.push_back(1); chk("sw200_mis", {31'b0, MisalignM});
        sb.push_back(0); chk("sw200_we", {31'b0, DramWe});
        @(posedge clk); #1;
        drv(1, 0, SZW, 0, 0, 32'h11, 32'h0); #1;
        sb.push_back(32'h0); chk("sw200_mem0", mem[0]);
        sb.push_back(1); chk("lw11_mis", {31'b0, MisalignM});
        sb.push_back(32'h0); chk("lw11_data", ReadDataM);

        // reset during MERGE
        drv(0, 1, SZB, 0, 0, 32'h11, 32'h00000099); #1;
        sb.push_back(1); chk("rstm_c1_stall", {31'b0, StallM});
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        sb.push_back(0); chk("rstm_we", {31'b0, DramWe});
        @(posedge clk); #1;
        rst = 1'b0;
        drv(1, 0, SZW, 0, 0, 32'h10, 32'h0); #1;
        sb.push_back(32'hBEEFAB55); chk("rstm_mem4", mem[4]);
        sb.push_back(32'hBEEFAB55); chk("rstm_idle_load", ReadDataM);
        sb.push_back(0); chk("rstm_idle_stall", {31'b0, StallM});

        // flushed word store
        drv(0, 1, SZW, 0, 1, 32'h10, 32'hDEADBEEF); #1;
        sb.push_back(0); chk("flush_we", {31'b0, DramWe});
        sb.push_back(0); chk("flush_stall", {31'b0, StallM});
        sb.push_back(0); chk("flush_mis", {31'b0, MisalignM});
        @(posedge clk); #1;
        drv(0, 0, SZW, 0, 0, 32'h0, 32'h0); #1;
        sb.push_back(32'hBEEFAB55); chk("flush_mem4", mem[4]);

        // word store, with a simultaneous load asserted
        drv(1, 1, SZW, 0, 0, 32'h20, 32'hCAFEF00D); #1;
        sb.push_back(1); chk("sw20_we", {31'b0, DramWe});
        sb.push_back(0); chk("sw20_stall", {31'b0, StallM});
        sb.push_back(32'h0); chk("sw20_rdata", ReadDataM);
        @(posedge clk); #1;
        drv(0, 0, SZW, 0, 0, 32'h0, 32'h0); #1;
        sb.push_back(32'hCAFEF00D); chk("sw20_mem8", mem[8]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
